// File: rtl/pi_rx_stream_reader.sv
// Host-side reader for the Radioberry RX IQ nibble link.
// Generates rx_clk, shifts in six nibbles per 24-bit word (MSB first) and emits each word
// on an AXI-stream style master port. Checks rx_last framing against the expected word index.
module pi_rx_stream_reader #(
    parameter int unsigned HALF_DIV    = 4,
    parameter int unsigned BURST_WORDS = 256,
    parameter int unsigned GAP_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        rx_samples,
    output logic        rx_clk,
    input  logic [3:0]  rx_data,
    input  logic        rx_last,
    output logic [23:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic        frame_err,
    input  logic        clr_err,
    output logic [15:0] burst_count
);

    localparam int unsigned DivW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned IdxW = $clog2(BURST_WORDS + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(HALF_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(BURST_WORDS - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShift, StEmit, StGap} state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            rx_clk_q, rx_clk_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      nib_q, nib_d;
    // Only the first five nibbles are held; the sixth goes straight into the output word.
    logic [19:0]     shreg_q, shreg_d;
    logic [23:0]     tdata_q, tdata_d;
    logic [IdxW-1:0] word_idx_q, word_idx_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [15:0]     burst_count_q, burst_count_d;
    logic            frame_err_q, frame_err_d;

    // Next-state logic: link clocking, nibble assembly, handshake and framing check.
    always_comb begin
        state_d       = state_q;
        rx_clk_d      = rx_clk_q;
        div_d         = div_q;
        nib_d         = nib_q;
        shreg_d       = shreg_q;
        tdata_d       = tdata_q;
        word_idx_d    = word_idx_q;
        gap_d         = gap_q;
        burst_count_d = burst_count_q;
        frame_err_d   = frame_err_q & ~clr_err;

        unique case (state_q)
            StIdle: begin
                rx_clk_d   = 1'b0;
                word_idx_d = '0;
                nib_d      = '0;
                div_d      = '0;
                if (enable && sync_q[1]) begin
                    state_d  = StShift;
                    rx_clk_d = 1'b1;
                end
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d    = '0;
                    shreg_d  = {shreg_q[15:0], rx_data};
                    rx_clk_d = ~rx_clk_q;
                    nib_d    = nib_q + 3'd1;
                    if (nib_q == 3'd5) begin
                        // Park rx_clk low so the link stalls while the word waits for accept.
                        rx_clk_d = 1'b0;
                        nib_d    = '0;
                        tdata_d  = {shreg_q, rx_data};
                        if (rx_last != (word_idx_q == IdxLast)) begin
                            frame_err_d = 1'b1;
                        end
                        state_d = StEmit;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StEmit: begin
                rx_clk_d = 1'b0;
                if (m_tready) begin
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_q < IdxLast) begin
                        state_d  = StShift;
                        rx_clk_d = 1'b1;
                    end else begin
                        burst_count_d = burst_count_q + 16'd1;
                        gap_d         = '0;
                        state_d       = StGap;
                    end
                end
            end
            StGap: begin
                // Give the gateware time to update its FIFO level and the flag to resync.
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; rx_samples passes through a 2-FF synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            sync_q        <= '0;
            rx_clk_q      <= 1'b0;
            div_q         <= '0;
            nib_q         <= '0;
            shreg_q       <= '0;
            tdata_q       <= '0;
            word_idx_q    <= '0;
            gap_q         <= '0;
            burst_count_q <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= {sync_q[0], rx_samples};
            rx_clk_q      <= rx_clk_d;
            div_q         <= div_d;
            nib_q         <= nib_d;
            shreg_q       <= shreg_d;
            tdata_q       <= tdata_d;
            word_idx_q    <= word_idx_d;
            gap_q         <= gap_d;
            burst_count_q <= burst_count_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign rx_clk      = rx_clk_q;
    assign m_tdata     = tdata_q;
    assign m_tvalid    = (state_q == StEmit);
    // Follows the word index, never the gateware's rx_last.
    assign m_tlast     = (state_q == StEmit) && (word_idx_q == IdxLast);
    assign busy        = (state_q != StIdle);
    assign frame_err   = frame_err_q;
    assign burst_count = burst_count_q;

endmodule

// File: tb/tb_pi_rx_stream_reader.sv
// Directed bench for pi_rx_stream_reader with a behavioural gateware nibble source.
module tb_pi_rx_stream_reader;

    localparam int BurstWords = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        rx_samples;
    logic        rx_clk;
    logic [3:0]  rx_data = '0;
    logic        rx_last = 1'b0;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        frame_err;
    logic        clr_err;
    logic [15:0] burst_count;

    int checks = 0;
    int errors = 0;
    int beat_wait = 0;

    // Gateware model state
    logic [23:0] words [BurstWords];
    int          last_word = 3;
    int          edge_cnt  = 0;
    int          edge_base = 0;

    pi_rx_stream_reader #(
        .HALF_DIV   (4),
        .BURST_WORDS(BurstWords),
        .GAP_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rx_samples (rx_samples),
        .rx_clk     (rx_clk),
        .rx_data    (rx_data),
        .rx_last    (rx_last),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .frame_err  (frame_err),
        .clr_err    (clr_err),
        .burst_count(burst_count)
    );

    always #5 clk = ~clk;

    // Gateware: present the next nibble (MSB first) on every rx_clk edge; rx_last on nibble 5.
    always @(rx_clk) begin
        int k;
        int w;
        int n;
        k = edge_cnt - edge_base;
        w = (k / 6) % BurstWords;
        n = k % 6;
        rx_data  = words[w][23 - 4 * n -: 4];
        rx_last  = (n == 5) && (w == last_word);
        edge_cnt = edge_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_burst(input string tag, input bit keep);
        bit ok;
        ok = 1'b0;
        edge_base  = edge_cnt;
        rx_samples = 1'b1;
        enable     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_start"}, 32'(ok), 32'd1);
        if (!keep) begin
            rx_samples = 1'b0;
            enable     = 1'b0;
        end
    endtask

    task automatic get_beat(input string tag, input logic [23:0] exp_d, input logic exp_l);
        bit ok;
        ok = 1'b0;
        beat_wait = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            beat_wait = i + 1;
            if (m_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check_eq({tag, "_data"}, 32'(m_tdata), 32'(exp_d));
            check_eq({tag, "_last"}, 32'(m_tlast), 32'(exp_l));
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int e0;
        bit bad;
        rst        = 1'b1;
        enable     = 1'b0;
        rx_samples = 1'b0;
        m_tready   = 1'b1;
        clr_err    = 1'b0;
        words[0] = 24'hABCDEF;
        words[1] = 24'h123456;
        words[2] = 24'h000001;
        words[3] = 24'hFFFFFF;
        last_word = 3;
        repeat (3) @(negedge clk);

        check_eq("rst_rx_clk", 32'(rx_clk), 32'd0);
        check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
        check_eq("rst_tdata", 32'(m_tdata), 32'd0);
        check_eq("rst_tlast", 32'(m_tlast), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_bcnt", 32'(burst_count), 32'd0);
        rst = 1'b0;

        // 1: clean burst, word rate 6*HALF_DIV+1 with tready high
        start_burst("t1", 1'b0);
        get_beat("t1_w0", 24'hABCDEF, 1'b0);
        get_beat("t1_w1", 24'h123456, 1'b0);
        check_eq("t1_rate", 32'(beat_wait), 32'd25);
        get_beat("t1_w2", 24'h000001, 1'b0);
        get_beat("t1_w3", 24'hFFFFFF, 1'b1);
        wait_idle("t1");
        check_eq("t1_ferr", 32'(frame_err), 32'd0);
        check_eq("t1_bcnt", 32'(burst_count), 32'd1);

        // 2: backpressure on word 1 for 50 cycles
        start_burst("t2", 1'b0);
        get_beat("t2_w0", 24'hABCDEF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        m_tready = 1'b0;
        get_beat("t2_w1", 24'h123456, 1'b0);
        e0  = edge_cnt;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (!m_tvalid || rx_clk || m_tlast || m_tdata != 24'h123456) bad = 1'b1;
        end
        check_eq("t2_stall_hold", 32'(bad), 32'd0);
        check_eq("t2_no_edges", 32'(edge_cnt - e0), 32'd0);
        m_tready = 1'b1;
        get_beat("t2_w2", 24'h000001, 1'b0);
        get_beat("t2_w3", 24'hFFFFFF, 1'b1);
        wait_idle("t2");
        check_eq("t2_bcnt", 32'(burst_count), 32'd2);

        // 3: rx_last on word 1; clear held across a fresh error on word 3
        last_word = 1;
        start_burst("t3", 1'b0);
        get_beat("t3_w0", 24'hABCDEF, 1'b0);
        check_eq("t3_ferr_w0", 32'(frame_err), 32'd0);
        get_beat("t3_w1", 24'h123456, 1'b0);
        check_eq("t3_ferr_w1", 32'(frame_err), 32'd1);
        clr_err = 1'b1;
        get_beat("t3_w2", 24'h000001, 1'b0);
        check_eq("t3_ferr_clr", 32'(frame_err), 32'd0);
        get_beat("t3_w3", 24'hFFFFFF, 1'b1);
        check_eq("t3_ferr_clr_vs_err", 32'(frame_err), 32'd1);
        clr_err = 1'b0;
        wait_idle("t3");
        check_eq("t3_ferr_sticky", 32'(frame_err), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        check_eq("t3_ferr_cleared", 32'(frame_err), 32'd0);
        check_eq("t3_bcnt", 32'(burst_count), 32'd3);
        last_word = 3;

        // 4: reset on the 3rd nibble of word 2, then a full burst from word 0
        start_burst("t4", 1'b0);
        get_beat("t4_w0", 24'hABCDEF, 1'b0);
        get_beat("t4_w1", 24'h123456, 1'b0);
        bad = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (edge_cnt - edge_base >= 15) begin
                bad = 1'b0;
                break;
            end
        end
        check_eq("t4_reach_nib2", 32'(bad), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t4_rx_clk", 32'(rx_clk), 32'd0);
        check_eq("t4_tvalid", 32'(m_tvalid), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_bcnt_rst", 32'(burst_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start_burst("t4b", 1'b0);
        get_beat("t4b_w0", 24'hABCDEF, 1'b0);
        get_beat("t4b_w1", 24'h123456, 1'b0);
        get_beat("t4b_w2", 24'h000001, 1'b0);
        get_beat("t4b_w3", 24'hFFFFFF, 1'b1);
        wait_idle("t4b");
        check_eq("t4b_ferr", 32'(frame_err), 32'd0);
        check_eq("t4b_bcnt", 32'(burst_count), 32'd1);

        // 5: enable dropped during word 1, rx_samples held high
        start_burst("t5", 1'b1);
        get_beat("t5_w0", 24'hABCDEF, 1'b0);
        enable = 1'b0;
        get_beat("t5_w1", 24'h123456, 1'b0);
        get_beat("t5_w2", 24'h000001, 1'b0);
        get_beat("t5_w3", 24'hFFFFFF, 1'b1);
        wait_idle("t5");
        e0  = edge_cnt;
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (busy || rx_clk) bad = 1'b1;
        end
        check_eq("t5_stay_idle", 32'(bad), 32'd0);
        check_eq("t5_no_edges", 32'(edge_cnt - e0), 32'd0);
        check_eq("t5_bcnt", 32'(burst_count), 32'd2);
        rx_samples = 1'b0;

        // 6: burst counter wraps from 0xFFFF to 0
        @(negedge clk);
        force dut.burst_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.burst_count_q;
        @(negedge clk);
        check_eq("t6_preload", 32'(burst_count), 32'h0000FFFF);
        start_burst("t6", 1'b0);
        get_beat("t6_w0", 24'hABCDEF, 1'b0);
        get_beat("t6_w1", 24'h123456, 1'b0);
        get_beat("t6_w2", 24'h000001, 1'b0);
        get_beat("t6_w3", 24'hFFFFFF, 1'b1);
        wait_idle("t6");
        check_eq("t6_wrap", 32'(burst_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
